dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory (async read, sync write) between two requesters: port 0 (CPU load/store unit) and port 1 (debug/loader or DMA master). It selects one requester per cycle, drives the memory's write-enable, address and write data, and returns registered read data with a valid strobe to the winning port. Burst-capped round-robin gives both ports forward progress; a compile-time option switches to fixed priority.

## Interface
- ADDR_WIDTH, 16, byte address width; matches the data memory.
- DATA_WIDTH, 32, data word width.
- MAX_BURST, 4, consecutive grants one port may hold while the other is requesting (≥1).

- clk  input  1  clock; everything is sampled on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- m0_req / m1_req  input  1  access request.
- m0_we / m1_we  input  1  1 = write, 0 = read; valid while req=1.
- m0_addr / m1_addr  input  ADDR_WIDTH  byte address.
- m0_wdata / m1_wdata  input  DATA_WIDTH  write data.
- m0_gnt / m1_gnt  output  1  access performed this cycle (combinational).
- m0_rvalid / m1_rvalid  output  1  registered read data valid.
- m0_rdata / m1_rdata  output  DATA_WIDTH  registered read data.
- mem_we  output  1  to data memory write enable.
- mem_addr  output  ADDR_WIDTH  to data memory address.
- mem_wdata  output  DATA_WIDTH  to data memory write data.
- mem_rdata  input  DATA_WIDTH  from data memory async read port.

## Operation
- State: owner ∈ {OWN_NONE, OWN_P0, OWN_P1}, last (last granted port), beat counter cnt (saturates at MAX_BURST).
- OWN_NONE: if exactly one req, grant it. If both request, grant the port ≠ last. Then owner←winner, cnt←1.
- OWN_Pk with req_k=1: keep granting k (cnt++, saturating) unless cnt==MAX_BURST and the other port requests. In that case grant the other port, owner←other, cnt←1.
- OWN_Pk with req_k=0: grant the other port if it requests (owner←other, cnt←1); otherwise owner←OWN_NONE, cnt←0.
- last←winner on every grant.
- At most one gnt per cycle. The winner's we/addr/wdata are muxed onto mem_*. mem_we = gnt & we_winner.
- No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Granted read: mk_rdata←mem_rdata and mk_rvalid←1 at the next edge. Otherwise rvalid←0 and rdata holds its value. Writes get no response; gnt is the acknowledgement.
- An ungranted requester keeps req and its operands stable until granted.

## Timing
- Grant latency 0 cycles: gnt is asserted in the same cycle as req when the port wins.
- The write commits at the edge that ends the grant cycle.
- Read response latency 1 cycle: rvalid is high for exactly one cycle after the grant cycle.
- Reset values: owner=OWN_NONE, last=P1 (so P0 wins the first tie), cnt=0, rvalid=0, rdata=0, all gnt=0, mem_we=0.
- rst=1 forces all gnt=0 and mem_we=0 combinationally in that cycle. A burst cut by reset is abandoned; no write occurs.
- Back-to-back grants to alternating ports produce rvalid on the matching port each cycle, with no bubble.
- Reset asserted while a rvalid is pending: the rvalid is suppressed.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins when both request. MAX_BURST and last are ignored for selection. Port 1 is granted only in cycles with m0_req=0.
- DMEM_ARB_FIXED_PRIO_EN undefined: burst-capped round-robin as described above.

## Structure
- Package dmem_arb_pkg holds the owner state typedef (OWN_NONE/OWN_P0/OWN_P1) and port index constants.
- Sub-module arb_pick2: combinational 2-way picker with inputs (req0, req1, owner, last, burst_done) and outputs a one-hot grant. It isolates the macro-dependent selection rule.

## Test plan
- Reset: hold rst 3 cycles with both reqs high -> gnt=0, mem_we=0, rvalid=0, rdata=0 throughout.
- P0 writes 0xDEADBEEF to addr 0x0010, then reads 0x0010 -> m0_gnt in both cycles; m0_rvalid=1 with m0_rdata=0xDEADBEEF one cycle after the read grant.
- Both ports request continuously, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0…; each read's rvalid goes to the correct port.
- P0 bursts 2 beats then drops req while P1 requests -> P1 granted in the next cycle with no idle cycle; owner switches, cnt=1.
- Reset asserted in beat 2 of a P1 write burst -> gnt and mem_we are 0 in that cycle; after release, a simultaneous request is won by P0.
- DMEM_ARB_FIXED_PRIO_EN defined, both request for 10 cycles -> m0_gnt for all 10 cycles; m1_gnt only after m0_req falls.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   owner_e : which port currently holds the memory (none / port 0 / port 1)
//   PORT0/1 : port index encoding used for the "last granted" register
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT0     = 1'b0;
  localparam logic PORT1     = 1'b1;
endpackage

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: one requester's access channel into the data-memory arbiter.
//   req/we/addr/wdata : request, held stable by the requester until gnt
//   gnt               : access performed this cycle (combinational)
//   rvalid/rdata      : registered read response, one cycle after a read grant
// Modports: master = requester side, slave = arbiter side.
interface dmem_arb_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_pick2.sv
// arb_pick2: combinational two-way picker, one-hot grant out.
//   req0/req1  : port requests
//   owner      : port that holds the memory right now
//   last       : last granted port (PORT0/PORT1)
//   burst_done : owner has used up its burst allowance
//   gnt        : one-hot grant {port1, port0}
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins);
// otherwise burst-capped round-robin.
module arb_pick2
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  owner_e     owner,
  input  logic       last,
  input  logic       burst_done,
  output logic [1:0] gnt
);
`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Ownership history plays no part in fixed priority.
  logic unused_rr;
  assign unused_rr = ^{owner, last, burst_done};

  always_comb begin
    gnt = 2'b00;
    if (req0)      gnt = 2'b01;
    else if (req1) gnt = 2'b10;
  end
`else
  always_comb begin
    gnt = 2'b00;
    case (owner)
      // Owner keeps the memory unless its burst is spent and the other waits.
      OWN_P0: begin
        if (req0 && !(burst_done && req1)) gnt = 2'b01;
        else if (req1)                     gnt = 2'b10;
      end
      OWN_P1: begin
        if (req1 && !(burst_done && req0)) gnt = 2'b10;
        else if (req0)                     gnt = 2'b01;
      end
      default: begin
        // Idle: a tie goes to the port that was not served last.
        if (req0 && req1) gnt = (last == PORT1) ? 2'b01 : 2'b10;
        else              gnt = {req1, req0};
      end
    endcase
  end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory (async read, sync write)
// between port 0 (CPU LSU) and port 1 (debug/DMA).
//   clk, rst  : clock, synchronous active-high reset
//   m0, m1    : requester channels (dmem_arb_if.slave)
//   mem_we/mem_addr/mem_wdata : to memory, zero when nothing is granted
//   mem_rdata : async read data from memory
// Build option: DMEM_ARB_FIXED_PRIO_EN (see arb_pick2).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arb_if.slave             m0,
  dmem_arb_if.slave             m1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [NUM_PORTS-1:0]                 req, we, pick, gnt, rvalid;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata, rdata;

  assign req   = {m1.req,   m0.req};
  assign we    = {m1.we,    m0.we};
  assign addr  = {m1.addr,  m0.addr};
  assign wdata = {m1.wdata, m0.wdata};

  owner_e           owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             burst_done;
  logic             winner;
  owner_e           win_own;

  assign burst_done = (cnt_q == CNT_W'(MAX_BURST));

  arb_pick2 u_pick (
    .req0       (req[0]),
    .req1       (req[1]),
    .owner      (owner_q),
    .last       (last_q),
    .burst_done (burst_done),
    .gnt        (pick)
  );

  // Reset kills the grant in the same cycle so an in-flight write is dropped.
  assign gnt     = rst ? '0 : pick;
  assign winner  = gnt[1];
  assign win_own = winner ? OWN_P1 : OWN_P0;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (|gnt) begin
      mem_we    = we[winner];
      mem_addr  = addr[winner];
      mem_wdata = wdata[winner];
    end
  end

  // Ownership / burst tracking
  always_comb begin
    owner_d = OWN_NONE;
    last_d  = last_q;
    cnt_d   = '0;
    if (|gnt) begin
      owner_d = win_own;
      last_d  = winner;
      if (owner_q != win_own)  cnt_d = CNT_W'(1);
      else if (burst_done)     cnt_d = cnt_q;
      else                     cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      last_q  <= PORT1;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-port read response: capture memory data at the end of a read grant.
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_resp
    logic                  rv_q;
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rv_q <= 1'b0;
        rd_q <= '0;
      end else begin
        rv_q <= gnt[k] & ~we[k];
        if (gnt[k] && !we[k]) rd_q <= mem_rdata;
      end
    end

    // A response still pending when reset arrives is not reported.
    assign rvalid[k] = rv_q & ~rst;
    assign rdata[k]  = rd_q;
  end

  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign m0.rvalid = rvalid[0];
  assign m1.rvalid = rvalid[1];
  assign m0.rdata  = rdata[0];
  assign m1.rdata  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small behavioural
// data memory (word i initialised to 0xA0000000 | i).
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  dmem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: filled on the first edge, then written on mem_we.
  bit [31:0] mem [256];
  bit        init_done;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
      init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_p0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
  endtask

`ifndef DMEM_ARB_FIXED_PRIO_EN
  bit exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`endif

  initial begin
    // Reset held 3 cycles with both ports requesting
    rst = 1'b1;
    set_p0(1, 1, 16'h0010, 32'h1111_1111);
    set_p1(1, 0, 16'h0040, 32'h0);
    for (int i = 0; i < 3; i++) begin
      samp();
      check("rst_gnt0", m0_if.gnt, 0);
      check("rst_gnt1", m1_if.gnt, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_rvalid0", m0_if.rvalid, 0);
      check("rst_rvalid1", m1_if.rvalid, 0);
      check("rst_rdata0", m0_if.rdata, 0);
      check("rst_rdata1", m1_if.rdata, 0);
      next();
    end
    rst = 1'b0;
    set_p0(0, 0, 0, 0);
    set_p1(0, 0, 0, 0);
    samp();
    check("idle_gnt0", m0_if.gnt, 0);
    check("idle_gnt1", m1_if.gnt, 0);
    check("idle_mem_addr", mem_addr, 0);

    // P0 write then read of 0x0010
    next();
    set_p0(1, 1, 16'h0010, 32'hDEAD_BEEF);
    samp();
    check("wr_gnt0", m0_if.gnt, 1);
    check("wr_gnt1", m1_if.gnt, 0);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h0010);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next();
    set_p0(1, 0, 16'h0010, 32'h0);
    samp();
    check("rd_gnt0", m0_if.gnt, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 32'h0010);
    check("rd_rvalid_early", m0_if.rvalid, 0);
    next();
    set_p0(0, 0, 0, 0);
    samp();
    check("rd_rvalid0", m0_if.rvalid, 1);
    check("rd_rdata0", m0_if.rdata, 32'hDEAD_BEEF);
    check("rd_rvalid1", m1_if.rvalid, 0);
    check("rd_idle_gnt0", m0_if.gnt, 0);
    next();
    samp();
    check("rd_rvalid_drop", m0_if.rvalid, 0);
    check("rd_rdata_hold", m0_if.rdata, 32'hDEAD_BEEF);

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Reset pulse so the first tie goes to P0, then continuous contention
    next();
    rst = 1'b1;
    samp();
    next();
    rst = 1'b0;
    set_p0(1, 0, 16'h0020, 0);
    set_p1(1, 0, 16'h0040, 0);
    for (int i = 0; i < 9; i++) begin
      samp();
      check($sformatf("rr_gnt0_%0d", i), m0_if.gnt, !exp_seq[i]);
      check($sformatf("rr_gnt1_%0d", i), m1_if.gnt, exp_seq[i]);
      if (i > 0) begin
        check($sformatf("rr_rvalid0_%0d", i), m0_if.rvalid, !exp_seq[i-1]);
        check($sformatf("rr_rvalid1_%0d", i), m1_if.rvalid, exp_seq[i-1]);
        if (exp_seq[i-1]) check($sformatf("rr_rdata1_%0d", i), m1_if.rdata, 32'hA000_0010);
        else              check($sformatf("rr_rdata0_%0d", i), m0_if.rdata, 32'hA000_0008);
      end
      next();
    end
    set_p0(0, 0, 0, 0);
    set_p1(0, 0, 0, 0);
    samp();
    check("rr_tail_rvalid0", m0_if.rvalid, 1);
    check("rr_tail_rdata0", m0_if.rdata, 32'hA000_0008);
    check("rr_tail_rvalid1", m1_if.rvalid, 0);

    // P0 two beats, then drops while P1 waits: P1 takes over immediately
    next();
    set_p0(1, 0, 16'h0020, 0);
    samp();
    check("hand_b1_gnt0", m0_if.gnt, 1);
    next();
    set_p1(1, 1, 16'h0080, 32'h1234_5678);
    samp();
    check("hand_b2_gnt0", m0_if.gnt, 1);
    check("hand_b2_gnt1", m1_if.gnt, 0);
    next();
    set_p0(0, 0, 0, 0);
    samp();
    check("hand_sw_gnt1", m1_if.gnt, 1);
    check("hand_sw_gnt0", m0_if.gnt, 0);
    check("hand_sw_mem_we", mem_we, 1);
    check("hand_sw_mem_addr", mem_addr, 32'h0080);
    check("hand_sw_mem_wdata", mem_wdata, 32'h1234_5678);
    check("hand_sw_rvalid0", m0_if.rvalid, 1);
    next();
    set_p0(1, 0, 16'h0020, 0);
    samp();
    check("hand_own_gnt1", m1_if.gnt, 1);
    check("hand_own_gnt0", m0_if.gnt, 0);
    next();
    set_p0(0, 0, 0, 0);
    set_p1(0, 0, 0, 0);
    samp();
    check("hand_wr_no_rvalid1", m1_if.rvalid, 0);
`endif

    // Reset in beat 2 of a P1 write burst
    next();
    set_p1(1, 1, 16'h0084, 32'hCAFE_F00D);
    samp();
    check("rb_b1_gnt1", m1_if.gnt, 1);
    check("rb_b1_mem_we", mem_we, 1);
    next();
    rst = 1'b1;
    set_p1(1, 1, 16'h0088, 32'h0BAD_F00D);
    samp();
    check("rb_rst_gnt0", m0_if.gnt, 0);
    check("rb_rst_gnt1", m1_if.gnt, 0);
    check("rb_rst_mem_we", mem_we, 0);
    next();
    rst = 1'b0;
    set_p0(1, 0, 16'h0088, 0);
    samp();
    check("rb_tie_gnt0", m0_if.gnt, 1);
    check("rb_tie_gnt1", m1_if.gnt, 0);
    next();
    set_p0(0, 0, 0, 0);
    samp();
    check("rb_p1_gnt1", m1_if.gnt, 1);
    check("rb_rvalid0", m0_if.rvalid, 1);
    check("rb_no_write", m0_if.rdata, 32'hA000_0022);
    next();
    set_p1(0, 0, 0, 0);
    set_p0(1, 0, 16'h0084, 0);
    samp();
    check("rb_rd84_gnt0", m0_if.gnt, 1);
    next();
    set_p0(0, 0, 0, 0);
    samp();
    check("rb_beat1_data", m0_if.rdata, 32'hCAFE_F00D);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Fixed priority: P0 holds the memory while it keeps requesting
    next();
    set_p0(1, 0, 16'h0020, 0);
    set_p1(1, 0, 16'h0040, 0);
    for (int i = 0; i < 10; i++) begin
      samp();
      check($sformatf("fp_gnt0_%0d", i), m0_if.gnt, 1);
      check($sformatf("fp_gnt1_%0d", i), m1_if.gnt, 0);
      next();
    end
    set_p0(0, 0, 0, 0);
    samp();
    check("fp_drop_gnt1", m1_if.gnt, 1);
    check("fp_drop_gnt0", m0_if.gnt, 0);
    next();
    set_p1(0, 0, 0, 0);
`endif

    samp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
